// File: rtl/key_conditioner.sv
// ----------------------------------------------------------------------------
// key_conditioner
//
// Front end for the RPN calculator. Takes the four active-low push keys and
// the mode/value switches straight from the board, synchronises them to clk,
// debounces each key independently and presents:
//   - a clean active-low key level,
//   - a one-cycle press pulse per accepted press,
//   - the mode/value switch settings captured on the pulse cycle,
//   - a running count of pulse cycles.
//
// Optional feature (compile-time macro KEYCOND_REPEAT_EN):
//   When defined, a held key auto-repeats. The first repeat pulse comes
//   RPT_DELAY cycles after the press pulse, then one every RPT_PERIOD
//   cycles while the key stays held (requires RPT_DELAY >= RPT_PERIOD).
//   Repeat pulses behave exactly like real presses for capture and counting.
//   When undefined, the repeat logic and its parameters do not exist.
//
// Parameters
//   NKEYS      number of keys (active-low)
//   DB_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   DB_W       debounce counter width, 2**DB_W > DB_CYCLES
//   RPT_DELAY  held cycles before first repeat   (KEYCOND_REPEAT_EN only)
//   RPT_PERIOD cycles between subsequent repeats (KEYCOND_REPEAT_EN only)
//
// Ports
//   clk        in   1      system clock, posedge
//   rst        in   1      asynchronous reset, active low
//   key_raw    in   NKEYS  raw keys, 0 = pressed, asynchronous
//   mode_raw   in   2      raw mode switches
//   val_raw    in   16     raw value switches
//   key_out    out  NKEYS  debounced key level, 0 = pressed
//   key_press  out  NKEYS  one-cycle pulse per accepted press (or repeat)
//   mode_out   out  2      mode captured on the most recent pulse cycle
//   val_out    out  16     value captured on the most recent pulse cycle
//   press_cnt  out  8      number of cycles with any key_press bit set
// ----------------------------------------------------------------------------
module key_conditioner #(
    parameter int NKEYS      = 4,
    parameter int DB_CYCLES  = 16,
    parameter int DB_W       = 5
`ifdef KEYCOND_REPEAT_EN
    ,
    parameter int RPT_DELAY  = 64,
    parameter int RPT_PERIOD = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_raw,
    input  logic [1:0]       mode_raw,
    input  logic [15:0]      val_raw,
    output logic [NKEYS-1:0] key_out,
    output logic [NKEYS-1:0] key_press,
    output logic [1:0]       mode_out,
    output logic [15:0]      val_out,
    output logic [7:0]       press_cnt
);

    // ------------------------------------------------------------------------
    // Per-key debounce states
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_REL    = 2'd0;  // released, stable
    localparam logic [1:0] ST_PEND_P = 2'd1;  // low seen, waiting for stability
    localparam logic [1:0] ST_HELD   = 2'd2;  // pressed, stable
    localparam logic [1:0] ST_PEND_R = 2'd3;  // high seen, waiting for stability

    localparam logic [DB_W-1:0] DC_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DC_LAST = DB_W'(DB_CYCLES - 1);

`ifdef KEYCOND_REPEAT_EN
    // The repeat counter only ever needs to reach RPT_DELAY-1.
    localparam int RPT_W = (RPT_DELAY > 1) ? $clog2(RPT_DELAY) : 1;
    localparam logic [RPT_W-1:0] RC_ONE    = RPT_W'(1);
    localparam logic [RPT_W-1:0] RC_LAST   = RPT_W'(RPT_DELAY - 1);
    // After a repeat fires, restart the count so the next pulse lands
    // RPT_PERIOD cycles later instead of RPT_DELAY cycles later.
    localparam logic [RPT_W-1:0] RC_RELOAD = RPT_W'(RPT_DELAY - RPT_PERIOD);
`endif

    // ------------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------------
    logic [NKEYS-1:0] key_s1_q, key_s2_q;
    logic [1:0]       mode_s1_q, mode_s2_q;
    logic [15:0]      val_s1_q, val_s2_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of its neighbours; blocking
    // assignments here would collapse the two synchroniser stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1_q  <= '1;
            key_s2_q  <= '1;
            mode_s1_q <= '1;
            mode_s2_q <= '1;
            val_s1_q  <= '1;
            val_s2_q  <= '1;
        end else begin
            key_s1_q  <= key_raw;
            key_s2_q  <= key_s1_q;
            mode_s1_q <= mode_raw;
            mode_s2_q <= mode_s1_q;
            val_s1_q  <= val_raw;
            val_s2_q  <= val_s1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce FSMs, output registers and press bookkeeping
    // ------------------------------------------------------------------------
    logic [NKEYS-1:0][1:0]      ks_q, ks_d;
    logic [NKEYS-1:0][DB_W-1:0] dc_q, dc_d;
    logic [NKEYS-1:0]           key_out_q, key_out_d;
    logic [NKEYS-1:0]           key_press_q, key_press_d;
    logic [1:0]                 mode_out_q, mode_out_d;
    logic [15:0]                val_out_q, val_out_d;
    logic [7:0]                 press_cnt_q, press_cnt_d;
`ifdef KEYCOND_REPEAT_EN
    logic [NKEYS-1:0][RPT_W-1:0] rc_q, rc_d;
`endif

    // NOTE: every signal assigned in this block gets a default at the top, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        ks_d        = ks_q;
        dc_d        = dc_q;
        key_out_d   = key_out_q;
        key_press_d = '0;
`ifdef KEYCOND_REPEAT_EN
        rc_d        = '0;
`endif

        for (int i = 0; i < NKEYS; i++) begin
            case (ks_q[i])
                ST_REL: begin
                    if (!key_s2_q[i]) begin
                        ks_d[i] = ST_PEND_P;
                        dc_d[i] = DC_ONE;
                    end else begin
                        dc_d[i] = '0;
                    end
                end

                ST_PEND_P: begin
                    if (key_s2_q[i]) begin
                        // Bounced back before becoming stable: drop it.
                        ks_d[i] = ST_REL;
                        dc_d[i] = '0;
                    end else if (dc_q[i] == DC_LAST) begin
                        ks_d[i]        = ST_HELD;
                        dc_d[i]        = '0;
                        key_out_d[i]   = 1'b0;
                        key_press_d[i] = 1'b1;
                    end else begin
                        dc_d[i] = dc_q[i] + DC_ONE;
                    end
                end

                ST_HELD: begin
                    if (key_s2_q[i]) begin
                        ks_d[i] = ST_PEND_R;
                        dc_d[i] = DC_ONE;
                    end
                end

                ST_PEND_R: begin
                    if (!key_s2_q[i]) begin
                        ks_d[i] = ST_HELD;
                        dc_d[i] = '0;
                    end else if (dc_q[i] == DC_LAST) begin
                        // Release accepted; releases never pulse.
                        ks_d[i]      = ST_REL;
                        dc_d[i]      = '0;
                        key_out_d[i] = 1'b1;
                    end else begin
                        dc_d[i] = dc_q[i] + DC_ONE;
                    end
                end

                default: begin
                    ks_d[i]      = ST_REL;
                    dc_d[i]      = '0;
                    key_out_d[i] = 1'b1;
                end
            endcase

`ifdef KEYCOND_REPEAT_EN
            // Count only while the key sits in HELD and is staying there; any
            // other cycle leaves rc_d at its cleared default, so a key that
            // bounces into PEND_R and back starts the repeat delay afresh.
            if (ks_q[i] == ST_HELD && ks_d[i] == ST_HELD) begin
                if (rc_q[i] == RC_LAST) begin
                    key_press_d[i] = 1'b1;
                    rc_d[i]        = RC_RELOAD;
                end else begin
                    rc_d[i] = rc_q[i] + RC_ONE;
                end
            end
`endif
        end

        // Capture and count are computed from the same next-state pulse that
        // loads key_press_q, so they become visible in the pulse cycle itself.
        mode_out_d  = mode_out_q;
        val_out_d   = val_out_q;
        press_cnt_d = press_cnt_q;
        if (key_press_d != '0) begin
            mode_out_d  = mode_s2_q;
            val_out_d   = val_s2_q;
            // One per pulse cycle, not one per key; wraps naturally at 8 bits.
            press_cnt_d = press_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_q        <= '0;  // ST_REL for every key
            dc_q        <= '0;
            key_out_q   <= '1;
            key_press_q <= '0;
            mode_out_q  <= '0;
            val_out_q   <= '0;
            press_cnt_q <= '0;
`ifdef KEYCOND_REPEAT_EN
            rc_q        <= '0;
`endif
        end else begin
            ks_q        <= ks_d;
            dc_q        <= dc_d;
            key_out_q   <= key_out_d;
            key_press_q <= key_press_d;
            mode_out_q  <= mode_out_d;
            val_out_q   <= val_out_d;
            press_cnt_q <= press_cnt_d;
`ifdef KEYCOND_REPEAT_EN
            rc_q        <= rc_d;
`endif
        end
    end

    assign key_out   = key_out_q;
    assign key_press = key_press_q;
    assign mode_out  = mode_out_q;
    assign val_out   = val_out_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_conditioner.sv
// ----------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner with DB_CYCLES=4 (DB_W=3), and with
// RPT_DELAY=8 / RPT_PERIOD=3 when KEYCOND_REPEAT_EN is defined.
// Inputs are driven and outputs sampled on the falling clock edge. Offsets
// below count rising edges from the first edge that samples a new key level.
// ----------------------------------------------------------------------------
module tb_key_conditioner;

    logic        clk;
    logic        rst;
    logic [3:0]  key_raw;
    logic [1:0]  mode_raw;
    logic [15:0] val_raw;
    logic [3:0]  key_out;
    logic [3:0]  key_press;
    logic [1:0]  mode_out;
    logic [15:0] val_out;
    logic [7:0]  press_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    key_conditioner #(
        .NKEYS      (4),
        .DB_CYCLES  (4),
        .DB_W       (3)
`ifdef KEYCOND_REPEAT_EN
        ,
        .RPT_DELAY  (8),
        .RPT_PERIOD (3)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .mode_raw  (mode_raw),
        .val_raw   (val_raw),
        .key_out   (key_out),
        .key_press (key_press),
        .mode_out  (mode_out),
        .val_out   (val_out),
        .press_cnt (press_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never returns.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pull the keys in 'keys' low for 'hold' sampled cycles, then release,
    // observing ncyc falling edges. hits bit j is set when any key_press bit
    // was high after rising edge j; rel_j is the first offset at which the
    // watched keys read released again after having read pressed.
    task automatic watch(input logic [3:0] keys, input int hold, input int ncyc,
                         output logic [63:0] hits, output logic [3:0] pv,
                         output logic low_seen, output int rel_j,
                         output logic [3:0] ko_held);
        hits     = '0;
        pv       = '0;
        low_seen = 1'b0;
        rel_j    = -1;
        ko_held  = '1;
        key_raw  = key_raw & ~keys;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (key_press != 4'h0) begin
                hits[i] = 1'b1;
                pv      = key_press;
            end
            if ((key_out & keys) != keys)
                low_seen = 1'b1;
            else if (low_seen && rel_j < 0)
                rel_j = i;
            if (i == hold - 1) begin
                ko_held = key_out;
                key_raw = key_raw | keys;
            end
        end
    endtask

    initial begin
        logic [63:0] hits;
        logic [3:0]  pv;
        logic        low_seen;
        int          rel_j;
        logic [3:0]  ko_held;
        int          exp_cnt;
        int          n_press;
        int          bad_press;

        // ---------------- 1: reset state ----------------
        rst      = 1'b0;
        key_raw  = 4'hF;
        mode_raw = 2'b00;
        val_raw  = 16'h0000;
        #6;
        check("rst_key_out",   key_out,   4'hF);
        check("rst_key_press", key_press, 4'h0);
        check("rst_press_cnt", press_cnt, 8'h00);
        check("rst_mode_out",  mode_out,  2'b00);
        check("rst_val_out",   val_out,   16'h0000);
        #21 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_key_out",   key_out,   4'hF);
            check("idle_key_press", key_press, 4'h0);
            check("idle_press_cnt", press_cnt, 8'h00);
            check("idle_mode_out",  mode_out,  2'b00);
            check("idle_val_out",   val_out,   16'h0000);
        end

        // ---------------- 2: clean press of key 0, held 20 cycles ----------------
        val_raw  = 16'h1234;
        mode_raw = 2'b01;
        watch(4'b0001, 20, 30, hits, pv, low_seen, rel_j, ko_held);
`ifdef KEYCOND_REPEAT_EN
        // press at +5, repeats at +13, +16, +19; +22 is past the release
        check("p0_hits", hits, 64'h0000_0000_0009_2020);
        exp_cnt = 4;
`else
        check("p0_hits", hits, 64'h0000_0000_0000_0020);
        exp_cnt = 1;
`endif
        check("p0_pulse_val",  pv,        4'b0001);
        check("p0_key_held",   ko_held,   4'hE);
        check("p0_release_at", rel_j,     25);
        check("p0_key_out",    key_out,   4'hF);
        check("p0_val_out",    val_out,   16'h1234);
        check("p0_mode_out",   mode_out,  2'b01);
        check("p0_press_cnt",  press_cnt, exp_cnt[7:0]);

        // ---------------- 3: bounce on key 1 ----------------
        val_raw  = 16'h5555;
        mode_raw = 2'b11;
        watch(4'b0010, 3, 12, hits, pv, low_seen, rel_j, ko_held);
        check("bounce_hits",      hits,           64'h0);
        check("bounce_key_low",   {7'd0, low_seen}, 8'd0);
        check("bounce_press_cnt", press_cnt,      exp_cnt[7:0]);
        check("bounce_val_hold",  val_out,        16'h1234);
        check("bounce_mode_hold", mode_out,       2'b01);

        // Exactly DB_CYCLES low samples is the shortest accepted press.
        watch(4'b0010, 4, 14, hits, pv, low_seen, rel_j, ko_held);
        exp_cnt++;
        check("min_hits",       hits,      64'h20);
        check("min_pulse_val",  pv,        4'b0010);
        check("min_release_at", rel_j,     9);
        check("min_press_cnt",  press_cnt, exp_cnt[7:0]);
        check("min_val_out",    val_out,   16'h5555);
        check("min_mode_out",   mode_out,  2'b11);

        // ---------------- 4: keys 2 and 3 together ----------------
        val_raw  = 16'hBEEF;
        mode_raw = 2'b10;
        watch(4'b1100, 10, 20, hits, pv, low_seen, rel_j, ko_held);
        exp_cnt++;
        check("dual_hits",       hits,      64'h20);
        check("dual_pulse_val",  pv,        4'b1100);
        check("dual_key_held",   ko_held,   4'h3);
        check("dual_release_at", rel_j,     15);
        check("dual_key_out",    key_out,   4'hF);
        check("dual_press_cnt",  press_cnt, exp_cnt[7:0]);
        check("dual_val_out",    val_out,   16'hBEEF);
        check("dual_mode_out",   mode_out,  2'b10);

        // ---------------- 5: press counter wrap ----------------
        n_press   = 255 - exp_cnt;
        bad_press = 0;
        for (int p = 0; p < n_press; p++) begin
            watch(4'b0001, 5, 12, hits, pv, low_seen, rel_j, ko_held);
            if (hits != 64'h20 || pv != 4'b0001) bad_press++;
        end
        check("wrap_bad_presses", bad_press, 0);
        check("wrap_cnt_ff",      press_cnt, 8'hFF);
        watch(4'b0001, 5, 12, hits, pv, low_seen, rel_j, ko_held);
        check("wrap_cnt_00",      press_cnt, 8'h00);
        check("wrap_last_hits",   hits,      64'h20);

        // ---------------- 6: reset mid-debounce ----------------
        val_raw  = 16'hA5C3;
        mode_raw = 2'b11;
        key_raw  = 4'hE;
        repeat (4) @(negedge clk);  // key 0 now in PEND_P, counter part way
        check("pend_key_out",   key_out,   4'hF);
        check("pend_press_cnt", press_cnt, 8'h00);
        rst = 1'b0;
        #1;
        check("mid_rst_key_out",   key_out,   4'hF);
        check("mid_rst_key_press", key_press, 4'h0);
        check("mid_rst_press_cnt", press_cnt, 8'h00);
        check("mid_rst_mode_out",  mode_out,  2'b00);
        check("mid_rst_val_out",   val_out,   16'h0000);
        #3 rst = 1'b1;
        // Key 0 is still low: debounce starts over from the first edge after
        // reset release, with no pulse on the release itself.
        watch(4'b0001, 21, 30, hits, pv, low_seen, rel_j, ko_held);
`ifdef KEYCOND_REPEAT_EN
        check("rerun_hits", hits, 64'h0000_0000_0049_2020);
        exp_cnt = 5;
`else
        check("rerun_hits", hits, 64'h0000_0000_0000_0020);
        exp_cnt = 1;
`endif
        check("rerun_pulse_val",  pv,        4'b0001);
        check("rerun_release_at", rel_j,     26);
        check("rerun_press_cnt",  press_cnt, exp_cnt[7:0]);
        check("rerun_val_out",    val_out,   16'hA5C3);
        check("rerun_mode_out",   mode_out,  2'b11);
        check("rerun_key_out",    key_out,   4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
